bcd_sseg_scan: RTL and testbench
================================

// Module: bcd_sseg_scan
// PURPOSE
//  Time-multiplexed 4-digit seven-segment driver; downstream consumer of the bin->BCD converter.
//  Captures a packed BCD word on a load strobe into a shadow register and drives one digit per slot.
//  Copies the shadow into the display register only at frame boundaries (digit 3 -> 0) so a value never tears.
//  Outputs (anodes, segments) are active-low, board-ready.
// PARAMETERS
//  REFRESH_DIV  100_000  clocks per digit slot (1 kHz/digit @ 100 MHz); legal range >= 2
//  CNT_W        $clog2(REFRESH_DIV)  slot counter width (derived; do not override)
// PORTS
//  clk         in   1   system clock, all logic on rising edge
//  reset_n     in   1   asynchronous, active-low reset
//  bcd_in      in   16  four BCD digits {d3,d2,d1,d0}; upstream pads 12-bit converter output with 4'h0
//  load        in   1   1-cycle strobe: capture bcd_in/dp_in into shadow
//  dp_in       in   4   decimal point per digit, active-high, captured with load
//  lz_blank    in   1   1 = blank leading zeros (live, not captured)
//  pending     out  1   shadow holds a value not yet displayed
//  frame_tick  out  1   1-cycle pulse at each frame boundary (index wraps 3->0)
//  an          out  4   digit anodes, active-low, one-hot-low
//  sseg        out  8   {dp,g,f,e,d,c,b,a}, active-low
// BEHAVIOUR
//  Reset: an=4'hF, sseg=8'hFF, pending=0, frame_tick=0, slot_cnt=0, dig_idx=0, shadow=active=0.
//  slot_cnt counts 0..REFRESH_DIV-1; at REFRESH_DIV-1 it clears and dig_idx increments mod 4.
//  Frame boundary = cycle where dig_idx goes 3->0: frame_tick=1 next cycle; if pending, active<=shadow, pending<=0.
//  load: shadow<=bcd_in/dp_in, pending<=1; repeated loads before a boundary overwrite (last wins).
//  load on boundary cycle: bcd_in/dp_in bypass straight into active, pending stays 0.
//  an/sseg registered from (dig_idx, active): change 1 cycle after dig_idx changes.
//  an: dig_idx k -> bit k low, others high.
//  Decode (a..g active-low, dp excluded): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90.
//  Nibble >9 shows dash (8'hBF, dp per dp_in); no error flag.
//  Leading-zero blank (lz_blank=1): digit k (k=3..1) shows 8'hFF (dp still applied) if it and all higher digits are 0.
//  Digit 0 never blanked. lz_blank=0: all digits decoded.
//  dp: sseg[7] = ~dp bit of current digit.
//  Reset mid-frame: everything returns to reset values immediately; display restarts at digit 0 after release.
// CONFIGURATION
//  SSEG_DIM_EN defined:
//   - adds input bright[3:0]
//   - anode of current digit driven low only while slot_cnt*16 < (bright+1)*REFRESH_DIV
//   - high (off) otherwise; bright=15 -> full on
//   - sseg unaffected; bright is sampled live
//  SSEG_DIM_EN undefined: no bright port; anode low for entire slot.
// TESTING (sim with REFRESH_DIV=4)
//  1. Reset held then released -> an=F, sseg=FF during reset; an cycles E,D,B,7 every 4 clks; all digits show C0.
//  2. load bcd_in=16'h0255, dp_in=0, lz_blank=1 -> pending=1 until boundary, then frame_tick.
//     Next frame: d0=92, d1=92, d2=A4, d3=FF.
//  3. Same value, lz_blank=0 -> d3=C0; bcd_in=16'h0000 lz_blank=1 -> d3..d1=FF, d0=C0.
//  4. Two loads (16'h1111 then 16'h2222) in one frame -> only 2222 displayed, never 1111; load on boundary cycle -> shown this frame, pending=0.
//  5. bcd_in=16'h00A3, dp_in=4'b0010 -> d1=3F (dash + dp), d0=B0; reset_n pulsed mid-slot -> outputs FF/F immediately, active=0.
//  6. SSEG_DIM_EN, REFRESH_DIV=16, bright=3 -> anode low 4 of 16 clks per slot; bright=15 -> low all 16.

Source files
------------

// File: rtl/bcd_sseg_scan.sv
// bcd_sseg_scan: time-multiplexed 4-digit seven-segment driver.
// A packed BCD word is captured into a shadow register on a load strobe and
// copied into the display register only at frame boundaries, so a
// multi-digit value never tears across a scan.
// Outputs an/sseg are active-low and registered.
// Optional feature: define SSEG_DIM_EN to add the bright[3:0] input, which
// shortens the anode on-time within each digit slot (PWM dimming).
//
// Load interface: load is a one-cycle strobe with no ready.  Every cycle in
// which load=1 is accepted; bcd_in/dp_in are sampled on that same rising
// edge.  A later strobe before the next frame boundary replaces the earlier
// one.
module bcd_sseg_scan #(
    parameter int REFRESH_DIV = 100_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] bcd_in,
    input  logic        load,
    input  logic [3:0]  dp_in,
    input  logic        lz_blank,
`ifdef SSEG_DIM_EN
    input  logic [3:0]  bright,
`endif
    output logic        pending,
    output logic        frame_tick,
    output logic [3:0]  an,
    output logic [7:0]  sseg
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] slot_cnt;
    logic [1:0]       dig_idx;
    logic [15:0]      shadow_bcd;
    logic [3:0]       shadow_dp;
    logic [15:0]      active_bcd;
    logic [3:0]       active_dp;

    logic             slot_last;
    logic             boundary;
    logic [3:0]       cur_nib;
    logic             cur_dp;
    logic             zero3, zero2, zero1;
    logic             blank;
    logic             an_on;
    logic [3:0]       next_an;
    logic [7:0]       next_sseg;

    assign slot_last = (slot_cnt == SLOT_LAST);
    assign boundary  = slot_last && (dig_idx == 2'd3);

    // Segment pattern a..g (active-low, bit 0 = a); non-BCD nibbles show a dash.
    function automatic logic [6:0] seg_of(input logic [3:0] nib);
        case (nib)
            4'd0:    seg_of = 7'h40;
            4'd1:    seg_of = 7'h79;
            4'd2:    seg_of = 7'h24;
            4'd3:    seg_of = 7'h30;
            4'd4:    seg_of = 7'h19;
            4'd5:    seg_of = 7'h12;
            4'd6:    seg_of = 7'h02;
            4'd7:    seg_of = 7'h78;
            4'd8:    seg_of = 7'h00;
            4'd9:    seg_of = 7'h10;
            default: seg_of = 7'h3F;
        endcase
    endfunction

    // Slot timer and digit index: one digit per REFRESH_DIV clocks, 0..3 round robin.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_cnt <= '0;
            dig_idx  <= 2'd0;
        end else if (slot_last) begin
            slot_cnt <= '0;
            dig_idx  <= dig_idx + 2'd1;
        end else begin
            slot_cnt <= slot_cnt + CNT_W'(1);
        end
    end

    // Shadow capture and tear-free transfer into the display register at the frame boundary.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_bcd <= '0;
            shadow_dp  <= '0;
            active_bcd <= '0;
            active_dp  <= '0;
            pending    <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= boundary;
            if (boundary) begin
                pending <= 1'b0;
                if (load) begin
                    // A load on the boundary goes straight to the display.
                    active_bcd <= bcd_in;
                    active_dp  <= dp_in;
                    shadow_bcd <= bcd_in;
                    shadow_dp  <= dp_in;
                end else if (pending) begin
                    active_bcd <= shadow_bcd;
                    active_dp  <= shadow_dp;
                end
            end else if (load) begin
                shadow_bcd <= bcd_in;
                shadow_dp  <= dp_in;
                pending    <= 1'b1;
            end
        end
    end

    // Select the current digit, apply leading-zero blanking and decode.
    always_comb begin
        cur_nib = 4'd0;
        cur_dp  = 1'b0;
        blank   = 1'b0;
        zero3   = (active_bcd[15:12] == 4'd0);
        zero2   = zero3 && (active_bcd[11:8] == 4'd0);
        zero1   = zero2 && (active_bcd[7:4] == 4'd0);
        case (dig_idx)
            2'd0: begin
                cur_nib = active_bcd[3:0];
                cur_dp  = active_dp[0];
            end
            2'd1: begin
                cur_nib = active_bcd[7:4];
                cur_dp  = active_dp[1];
                blank   = lz_blank && zero1;
            end
            2'd2: begin
                cur_nib = active_bcd[11:8];
                cur_dp  = active_dp[2];
                blank   = lz_blank && zero2;
            end
            default: begin
                cur_nib = active_bcd[15:12];
                cur_dp  = active_dp[3];
                blank   = lz_blank && zero3;
            end
        endcase
        next_sseg = {~cur_dp, (blank ? 7'h7F : seg_of(cur_nib))};
    end

`ifdef SSEG_DIM_EN
    // Anode stays lit for the first (bright+1)/16 of each slot.
    always_comb begin
        an_on = ((32'(slot_cnt) << 4) < ((32'(bright) + 32'd1) * 32'(REFRESH_DIV)));
    end
`else
    // Anode lit for the whole slot.
    always_comb begin
        an_on = 1'b1;
    end
`endif

    // One-hot-low anode for the current digit, or all off while dimmed.
    always_comb begin
        next_an = an_on ? ~(4'b0001 << dig_idx) : 4'hF;
    end

    // Registered, glitch-free board outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an   <= 4'hF;
            sseg <= 8'hFF;
        end else begin
            an   <= next_an;
            sseg <= next_sseg;
        end
    end

endmodule

// File: tb/tb_bcd_sseg_scan.sv
// tb_bcd_sseg_scan: directed bench for bcd_sseg_scan with REFRESH_DIV=4.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_bcd_sseg_scan;

    localparam int DIV = 4;

    logic        clk;
    logic        reset_n;
    logic [15:0] bcd_in;
    logic        load;
    logic [3:0]  dp_in;
    logic        lz_blank;
    logic [3:0]  bright;
    logic        pending;
    logic        frame_tick;
    logic [3:0]  an;
    logic [7:0]  sseg;

    int vectors = 0;
    int miscompares = 0;

    bcd_sseg_scan #(.REFRESH_DIV(DIV)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bcd_in     (bcd_in),
        .load       (load),
        .dp_in      (dp_in),
        .lz_blank   (lz_blank),
`ifdef SSEG_DIM_EN
        .bright     (bright),
`endif
        .pending    (pending),
        .frame_tick (frame_tick),
        .an         (an),
        .sseg       (sseg)
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Advance until frame_tick is seen, bounded to 40 cycles.
    task automatic wait_tick(input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (frame_tick !== 1'b1 && n < 40);
        chk({tag, " frame_tick wait"}, {7'h0, frame_tick}, 8'h01);
    endtask

    // Check a full frame starting from the cycle after a boundary (or reset release).
    task automatic check_frame(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] e [4];
        logic [3:0] exp_an;
        int         slot;
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int i = 0; i < 16; i++) begin
            step();
            slot   = i % 4;
            exp_an = ~(4'b0001 << (i / 4));
`ifdef SSEG_DIM_EN
            if (!((slot * 16) < ((int'(bright) + 1) * DIV)))
                exp_an = 4'hF;
`endif
            chk($sformatf("%s d%0d s%0d an", tag, i / 4, slot), {4'h0, an}, {4'h0, exp_an});
            chk($sformatf("%s d%0d s%0d sseg", tag, i / 4, slot), sseg, e[i / 4]);
            chk($sformatf("%s c%0d frame_tick", tag, i), {7'h0, frame_tick},
                (i == 15) ? 8'h01 : 8'h00);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        load     = 1'b0;
        bcd_in   = 16'h0000;
        dp_in    = 4'h0;
        lz_blank = 1'b0;
        bright   = 4'hF;

        // Reset held: outputs dark.
        repeat (3) step();
        chk("reset an", {4'h0, an}, 8'h0F);
        chk("reset sseg", sseg, 8'hFF);
        chk("reset pending", {7'h0, pending}, 8'h00);
        chk("reset frame_tick", {7'h0, frame_tick}, 8'h00);

        // Release: scan E,D,B,7 with all zeros shown.
        reset_n = 1'b1;
        check_frame("t1", 8'hC0, 8'hC0, 8'hC0, 8'hC0);

        // Load 0255 with leading-zero blanking.
        bcd_in = 16'h0255; dp_in = 4'h0; lz_blank = 1'b1; load = 1'b1;
        step();
        load = 1'b0;
        chk("t2 pending after load", {7'h0, pending}, 8'h01);
        step();
        chk("t2 pending held", {7'h0, pending}, 8'h01);
        wait_tick("t2");
        chk("t2 pending cleared", {7'h0, pending}, 8'h00);
        check_frame("t2", 8'h92, 8'h92, 8'hA4, 8'hFF);

        // Blanking off is live.
        lz_blank = 1'b0;
        check_frame("t3 lz0", 8'h92, 8'h92, 8'hA4, 8'hC0);

        // All zeros blanked down to digit 0.
        bcd_in = 16'h0000; lz_blank = 1'b1; load = 1'b1;
        step();
        load = 1'b0;
        wait_tick("t3");
        check_frame("t3 zero", 8'hC0, 8'hFF, 8'hFF, 8'hFF);

        // Two loads in one frame: last wins.
        bcd_in = 16'h1111; load = 1'b1;
        step();
        load = 1'b0;
        repeat (2) step();
        bcd_in = 16'h2222; load = 1'b1;
        step();
        load = 1'b0;
        wait_tick("t4");
        chk("t4 pending cleared", {7'h0, pending}, 8'h00);
        check_frame("t4 last", 8'hA4, 8'hA4, 8'hA4, 8'hA4);

        // Load exactly on the boundary cycle: bypass, no pending.
        repeat (15) step();
        bcd_in = 16'h3333; load = 1'b1;
        step();
        load = 1'b0;
        chk("t4 bypass frame_tick", {7'h0, frame_tick}, 8'h01);
        chk("t4 bypass pending", {7'h0, pending}, 8'h00);
        check_frame("t4 bypass", 8'hB0, 8'hB0, 8'hB0, 8'hB0);

        // Remaining decode values plus decimal points.
        bcd_in = 16'h9876; dp_in = 4'b1001; load = 1'b1;
        step();
        load = 1'b0;
        wait_tick("dec1");
        check_frame("dec1", 8'h02, 8'hF8, 8'h80, 8'h10);

        bcd_in = 16'h4140; dp_in = 4'b0000; load = 1'b1;
        step();
        load = 1'b0;
        wait_tick("dec2");
        check_frame("dec2", 8'hC0, 8'h99, 8'hF9, 8'h99);

        // Non-BCD nibble shows a dash with its dp.
        bcd_in = 16'h00A3; dp_in = 4'b0010; load = 1'b1;
        step();
        load = 1'b0;
        wait_tick("t5");
        check_frame("t5 dash", 8'hB0, 8'h3F, 8'hFF, 8'hFF);

        // Reset mid-slot with a pending value.
        step();
        bcd_in = 16'h5555; dp_in = 4'hF; load = 1'b1;
        step();
        load = 1'b0;
        chk("t5 pending before reset", {7'h0, pending}, 8'h01);
        step();
        reset_n = 1'b0;
        #1;
        chk("t5 async an", {4'h0, an}, 8'h0F);
        chk("t5 async sseg", sseg, 8'hFF);
        chk("t5 async pending", {7'h0, pending}, 8'h00);
        step();
        reset_n = 1'b1;
        check_frame("t5 post-reset", 8'hC0, 8'hFF, 8'hFF, 8'hFF);
        check_frame("t5 shadow cleared", 8'hC0, 8'hFF, 8'hFF, 8'hFF);

`ifdef SSEG_DIM_EN
        // Dimmed: anode lit only for part of each slot.
        bright = 4'd3;
        check_frame("dim3", 8'hC0, 8'hFF, 8'hFF, 8'hFF);
        bright = 4'd15;
        check_frame("dim15", 8'hC0, 8'hFF, 8'hFF, 8'hFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
